// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_pkg;

    localparam int DEF_WIDTH = 32;
    // Last iteration index of the one-bit-per-cycle loops.
    localparam int ITER_LAST = 31;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/multdiv_negate.sv
// Conditional two's-complement: used to take operand magnitudes and to
// restore the sign of the product, quotient and remainder.
module multdiv_negate #(
    parameter int W = 64
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit producing HI/LO for mfhi/mflo.
// Magnitudes are processed unsigned (shift-add multiply, restoring divide),
// one bit per cycle, and the sign is restored in the FIX state.
// Optional macro MULTDIV_ZERO_SKIP_EN: a mult with a zero operand bypasses
// the iteration loop and completes after one edge with hi=lo=0.
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t               state, nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opnd;     // multiplicand or divisor magnitude
    logic                 op_q;
    logic                 neg_q;    // negate product / quotient
    logic                 neg_r;    // negate remainder
    logic                 zskip;    // bypass the loop (div by zero, or zero mult when enabled)
    logic                 zero_op;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       psum, trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    multdiv_negate #(.W(WIDTH)) u_abs_a (.din(srcA), .neg(srcA[WIDTH-1]), .dout(abs_a));
    multdiv_negate #(.W(WIDTH)) u_abs_b (.din(srcB), .neg(srcB[WIDTH-1]), .dout(abs_b));

    multdiv_negate #(.W(2*WIDTH)) u_fix_p (.din(acc), .neg(neg_q), .dout(prod_fix));
    multdiv_negate #(.W(WIDTH)) u_fix_q (.din(acc[WIDTH-1:0]), .neg(neg_q), .dout(quot_fix));
    multdiv_negate #(.W(WIDTH)) u_fix_r (.din(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .dout(rem_fix));

    // Shift-add step keeps the carry out of the upper half.
    assign psum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    // Restoring-divide trial subtract; bit WIDTH is the borrow.
    assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

`ifdef MULTDIV_ZERO_SKIP_EN
    assign zero_op = (op == OP_DIV) ? (srcB == '0) : ((srcA == '0) || (srcB == '0));
`else
    assign zero_op = (op == OP_DIV) && (srcB == '0);
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (start) nxt = (op == OP_DIV) ? DIV : MULT;
            MULT,
            DIV: begin
                if (zskip)                    nxt = DONE;
                else if (cnt == CW'(ITER_LAST)) nxt = FIX;
            end
            FIX:  nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result write-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zskip    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    opnd     <= (op == OP_DIV) ? abs_b : abs_a;
                    acc      <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? abs_a : abs_b)};
                    op_q     <= op;
                    neg_q    <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
                    neg_r    <= (op == OP_DIV) ? srcA[WIDTH-1] : (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                    zskip    <= zero_op;
                    cnt      <= '0;
                    div_zero <= 1'b0;
                end
                MULT: begin
                    if (zskip) begin
                        hi <= '0;
                        lo <= '0;
                    end else begin
                        acc <= {psum, acc[WIDTH-1:1]};
                        cnt <= cnt + CW'(1);
                    end
                end
                DIV: begin
                    if (zskip) begin
                        div_zero <= 1'b1;
                    end else begin
                        acc <= trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                            : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    if (op_q == OP_DIV) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed expected values.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

`ifdef MULTDIV_ZERO_SKIP_EN
    localparam int ZMULT_EDGES = 1;
`else
    localparam int ZMULT_EDGES = 33;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at the negedge after the start-sampling edge. Counts edges
    // until done is seen (bounded), tracking that busy stays high.
    task automatic wait_done(output int n, output bit bok);
        n = 0;
        bok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) bok = 1'b0;
            @(posedge clk); n++;
            @(negedge clk);
        end
        if (!busy) bok = 1'b0;
    endtask

    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                       input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bit bok;
        launch(o, a, b);
        wait_done(n, bok);
        chk({tag, ".edges"}, 64'(n), 64'(exp_n));
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, ".busy"}, 64'(bok), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".release"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int  n;
        bit  bok;
        bit  saw_done;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dz",   64'(div_zero), 64'd0);
        chk("rst.hi",   64'(hi), 64'd0);
        chk("rst.lo",   64'(lo), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run("mul7xm3",  1'b0, 32'd7,          32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("mulmin2",  1'b0, 32'h8000_0000,  32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000);
        run("mulm5x6",  1'b0, 32'hFFFF_FFFB,  32'h0000_0006, 33, 32'hFFFF_FFFF, 32'hFFFF_FFE2);
        run("divm7d2",  1'b1, 32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div7dm2",  1'b1, 32'd7,          32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        run("div100d7", 1'b1, 32'd100,        32'd7,         33, 32'd2,         32'd14);
        run("divovf",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);

        // Divide by zero: one edge, flag set, hi/lo keep the previous result
        run("div5d0",   1'b1, 32'd5,          32'd0,         1,  32'h0000_0000, 32'h8000_0000);
        chk("div5d0.dz", 64'(div_zero), 64'd1);

        // Next accepted start clears the sticky flag
        launch(1'b0, 32'd2, 32'd3);
        chk("dzclr", 64'(div_zero), 64'd0);
        wait_done(n, bok);
        chk("mul2x3.lo", 64'(lo), 64'd6);
        @(posedge clk); @(negedge clk);

        // Start pulsed at edge 10 of a running mult is ignored
        launch(1'b0, 32'd100, 32'd200);
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 1'b1; srcA = 32'd9; srcB = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bok);
        chk("ign.edges", 64'(n + 10), 64'd33);
        chk("ign.lo",    64'(lo), 64'd20000);
        chk("ign.hi",    64'(hi), 64'd0);
        @(posedge clk); @(negedge clk);

        // Reset in the middle of an operation aborts it
        launch(1'b0, 32'd11, 32'd13);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.hi",   64'(hi), 64'd0);
        chk("abort.lo",   64'(lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort.nodone", 64'(saw_done), 64'd0);

        // Zero-operand mult, from a non-zero previous result
        run("mul3x5",   1'b0, 32'd3, 32'd5,     33, 32'd0, 32'd15);
        run("mul0xk",   1'b0, 32'd0, 32'd12345, ZMULT_EDGES, 32'd0, 32'd0);
        run("mulkx0",   1'b0, 32'hFFFF_FFFF, 32'd0, ZMULT_EDGES, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
